// File: rtl/wb_dual_arbiter.sv
// Two-master pipelined Wishbone arbiter: master A (fetch) and master B (memory) share one bus port.
// Define WBARB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority (A wins).
module wb_dual_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_a_cyc,
  input  logic          i_a_stb,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_data,
  output logic          o_a_ack,
  output logic          o_a_stall,
  output logic          o_a_err,
  input  logic          i_b_cyc,
  input  logic          i_b_stb,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_data,
  output logic          o_b_ack,
  output logic          o_b_stall,
  output logic          o_b_err,
  output logic          o_cyc,
  output logic          o_stb,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  input  logic          i_ack,
  input  logic          i_stall,
  input  logic          i_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_t;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  owner_t r_owner;
  logic   r_last;
  logic   both_pick_b;

`ifdef WBARB_ROUND_ROBIN_EN
  // On a tie the master that was not granted most recently wins.
  assign both_pick_b = (r_last == LAST_A);
`else
  logic unused_last;
  assign both_pick_b = 1'b0;
  assign unused_last = r_last;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner <= IDLE;
      r_last  <= LAST_B;
    end else begin
      case (r_owner)
        IDLE: begin
          if (i_a_cyc && (!i_b_cyc || !both_pick_b)) begin
            r_owner <= OWN_A;
            r_last  <= LAST_A;
          end else if (i_b_cyc) begin
            r_owner <= OWN_B;
            r_last  <= LAST_B;
          end
        end
        // The grant is held until the owner drops cyc; a waiting master takes over directly.
        OWN_A: begin
          if (!i_a_cyc) begin
            if (i_b_cyc) begin
              r_owner <= OWN_B;
              r_last  <= LAST_B;
            end else begin
              r_owner <= IDLE;
            end
          end
        end
        OWN_B: begin
          if (!i_b_cyc) begin
            if (i_a_cyc) begin
              r_owner <= OWN_A;
              r_last  <= LAST_A;
            end else begin
              r_owner <= IDLE;
            end
          end
        end
        default: r_owner <= IDLE;
      endcase
    end
  end

  // Request mux and response routing are purely combinational so the bus sees no added latency.
  always_comb begin
    o_cyc     = 1'b0;
    o_stb     = 1'b0;
    o_we      = i_a_we;
    o_addr    = i_a_addr;
    o_data    = i_a_data;
    o_a_ack   = 1'b0;
    o_a_stall = 1'b1;
    o_a_err   = 1'b0;
    o_b_ack   = 1'b0;
    o_b_stall = 1'b1;
    o_b_err   = 1'b0;
    case (r_owner)
      OWN_A: begin
        o_cyc     = i_a_cyc;
        o_stb     = i_a_stb;
        o_a_stall = i_stall;
        o_a_ack   = i_a_cyc & i_ack;
        o_a_err   = i_a_cyc & i_err;
      end
      OWN_B: begin
        o_cyc     = i_b_cyc;
        o_stb     = i_b_stb;
        o_we      = i_b_we;
        o_addr    = i_b_addr;
        o_data    = i_b_data;
        o_b_stall = i_stall;
        o_b_ack   = i_b_cyc & i_ack;
        o_b_err   = i_b_cyc & i_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_dual_arbiter.sv
// Scoreboard bench for wb_dual_arbiter: directed scenarios followed by random traffic,
// with expected outputs from a grant-rule reference model.
module tb_wb_dual_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 3 + AW + DW + 6;

  // clock / reset
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  logic i_rst;

  logic          i_a_cyc, i_a_stb, i_a_we;
  logic [AW-1:0] i_a_addr;
  logic [DW-1:0] i_a_data;
  logic          o_a_ack, o_a_stall, o_a_err;
  logic          i_b_cyc, i_b_stb, i_b_we;
  logic [AW-1:0] i_b_addr;
  logic [DW-1:0] i_b_data;
  logic          o_b_ack, o_b_stall, o_b_err;
  logic          o_cyc, o_stb, o_we;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic          i_ack, i_stall, i_err;

  wb_dual_arbiter #(.AW(AW), .DW(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we),
    .i_a_addr(i_a_addr), .i_a_data(i_a_data),
    .o_a_ack(o_a_ack), .o_a_stall(o_a_stall), .o_a_err(o_a_err),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we),
    .i_b_addr(i_b_addr), .i_b_data(i_b_data),
    .o_b_ack(o_b_ack), .o_b_stall(o_b_stall), .o_b_err(o_b_err),
    .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr), .o_data(o_data),
    .i_ack(i_ack), .i_stall(i_stall), .i_err(i_err)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

`ifdef WBARB_ROUND_ROBIN_EN
  bit rr = 1'b1;
`else
  bit rr = 1'b0;
`endif

  // Reference model: who holds the bus (0 none, 1 A, 2 B) and who was granted last.
  int m_owner = 0;
  int m_last  = 2;

  function automatic logic [W-1:0] model_out();
    logic cyc, stb, we, aa, as, ae, ba, bs, be;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    cyc = 1'b0; stb = 1'b0; we = i_a_we; addr = i_a_addr; data = i_a_data;
    aa = 1'b0; as = 1'b1; ae = 1'b0; ba = 1'b0; bs = 1'b1; be = 1'b0;
    if (m_owner == 1) begin
      cyc = i_a_cyc; stb = i_a_stb;
      as = i_stall; aa = i_a_cyc && i_ack; ae = i_a_cyc && i_err;
    end else if (m_owner == 2) begin
      cyc = i_b_cyc; stb = i_b_stb; we = i_b_we; addr = i_b_addr; data = i_b_data;
      bs = i_stall; ba = i_b_cyc && i_ack; be = i_b_cyc && i_err;
    end
    return {cyc, stb, we, addr, data, aa, as, ae, ba, bs, be};
  endfunction

  // Grant rule: an owner keeps the bus while its cyc is high; otherwise the requesters,
  // minus the master that just let go, compete and ties go by priority or round-robin.
  task automatic model_update();
    bit req_a, req_b;
    int prev, winner;
    if (i_rst) begin
      m_owner = 0;
      m_last  = 2;
    end else if (!(m_owner == 1 && i_a_cyc) && !(m_owner == 2 && i_b_cyc)) begin
      prev  = m_owner;
      req_a = i_a_cyc && prev != 1;
      req_b = i_b_cyc && prev != 2;
      if (req_a && req_b) winner = (rr && m_last == 1) ? 2 : 1;
      else if (req_a)     winner = 1;
      else if (req_b)     winner = 2;
      else                winner = 0;
      m_owner = winner;
      if (winner != 0) m_last = winner;
    end
  endtask

  // driver: inputs are set at the falling edge, expectation queued, model advanced at the rising edge
  task automatic step();
    exp_q.push_back(model_out());
    @(posedge i_clk);
    model_update();
    @(negedge i_clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle_inputs();
    i_a_cyc = 0; i_a_stb = 0; i_a_we = 0; i_a_addr = '0; i_a_data = '0;
    i_b_cyc = 0; i_b_stb = 0; i_b_we = 0; i_b_addr = '0; i_b_data = '0;
    i_ack = 0; i_stall = 0; i_err = 0;
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] exp_v, got;
    forever begin
      @(negedge i_clk);
      #2;
      while (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got = {o_cyc, o_stb, o_we, o_addr, o_data,
               o_a_ack, o_a_stall, o_a_err, o_b_ack, o_b_stall, o_b_err};
        checks++;
        if (got[W-1:6] !== exp_v[W-1:6]) begin
          errors++;
          $display("FAIL bus t=%0t got cyc/stb/we/addr/data=%h expected %h", $time, got[W-1:6], exp_v[W-1:6]);
        end
        checks++;
        if (got[5:0] !== exp_v[5:0]) begin
          errors++;
          $display("FAIL resp t=%0t got a_ack/stall/err,b_ack/stall/err=%b expected %b", $time, got[5:0], exp_v[5:0]);
        end
      end
    end
  end

  initial begin
    idle_inputs();
    i_rst = 1;
    @(posedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk);
    model_update();
    steps(2);                       // reset state held
    i_rst = 0;
    step();

    // A single read
    i_a_cyc = 1; i_a_stb = 1; i_a_addr = 32'h0000_1000;
    steps(2);
    i_ack = 1; step();
    i_ack = 0; i_a_stb = 0; step();
    i_a_cyc = 0; steps(2);

    // Simultaneous request from idle
    i_a_cyc = 1; i_b_cyc = 1; i_a_stb = 1; i_b_stb = 1;
    i_a_addr = 32'h0000_2000; i_b_addr = 32'h0000_3000; i_b_we = 1; i_b_data = 32'hdead_beef;
    steps(4);
    i_a_cyc = 0; steps(3);
    i_b_cyc = 0; steps(2);

    // A holds for 10 cycles while B keeps requesting, with acks on the bus
    i_a_cyc = 1; i_b_cyc = 1; i_ack = 1;
    steps(11);
    i_a_cyc = 0; steps(3);
    i_b_cyc = 0; i_ack = 0; steps(2);

    // Owners drop cyc for one cycle and immediately re-request
    i_a_cyc = 1; i_b_cyc = 1;
    for (int k = 0; k < 8; k++) begin
      steps(2);
      if (m_owner == 1) i_a_cyc = 0;
      else if (m_owner == 2) i_b_cyc = 0;
      step();
      i_a_cyc = 1; i_b_cyc = 1;
    end
    i_a_cyc = 0; i_b_cyc = 0; steps(3);

    // A re-requests after release with no contender
    i_a_cyc = 1; steps(2);
    i_a_cyc = 0; step();
    i_a_cyc = 1; steps(3);
    i_a_cyc = 0; step();

    // Spurious responses while idle, error during B ownership
    i_ack = 1; i_err = 1; steps(2);
    i_ack = 0;
    i_b_cyc = 1; steps(3);
    i_err = 0; i_b_cyc = 0; steps(2);

    // Reset in the middle of a stalled B cycle
    i_b_cyc = 1; i_stall = 1; steps(3);
    i_rst = 1; step();
    i_rst = 0; steps(3);
    i_b_cyc = 0; i_stall = 0; steps(2);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0) i_a_cyc = ~i_a_cyc;
      if ($urandom_range(0, 5) == 0) i_b_cyc = ~i_b_cyc;
      i_a_stb = 1'($urandom_range(0, 1));
      i_b_stb = 1'($urandom_range(0, 1));
      i_a_we = 1'($urandom_range(0, 1));
      i_b_we = 1'($urandom_range(0, 1));
      i_a_addr = $urandom; i_a_data = $urandom;
      i_b_addr = $urandom; i_b_data = $urandom;
      i_ack = 1'($urandom_range(0, 1));
      i_stall = 1'($urandom_range(0, 1));
      i_err = ($urandom_range(0, 7) == 0);
      i_rst = ($urandom_range(0, 149) == 0);
      step();
    end
    i_rst = 0;
    idle_inputs();
    steps(2);

    @(negedge i_clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d queued expectations left required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
